tlb_lookup_cache: RTL

Parametrised, registered successor to the fetch-stage TLB lookup. Holds NUM_ENTRIES fully-associative translations in flops. Serves one lookup per cycle over a valid/ready handshake, with a one-cycle registered response carrying PFN, page-fault and CS-limit protection status. Adds in-block fill with first-invalid/round-robin replacement, single-VPN and global invalidate, and saturating hit/miss counters. Instanced by fetch (and later by memory stage) in front of the I-cache tag compare.

---
 rtl/tlb_pkg.sv | 33 +++
 rtl/tlb_lookup_cache_if.sv | 31 +++
 rtl/tlb_match_array.sv | 30 +++
 rtl/tlb_lookup_cache.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared defaults and entry-layout helpers for the fetch-stage TLB lookup cache.
// Entries are packed as {valid, present, vpn, pfn} with pfn in the low bits.
package tlb_pkg;

  localparam int DEF_NUM_ENTRIES = 8;
  localparam int DEF_VA_W        = 32;
  localparam int DEF_PAGE_OFF_W  = 12;
  localparam int DEF_PFN_W       = 3;
  localparam int DEF_LIMIT_W     = 20;
  localparam int DEF_LINE_OFF_W  = 5;
  localparam int DEF_CNT_W       = 16;

  function automatic int vpn_width(input int va_w, input int page_off_w);
    return va_w - page_off_w;
  endfunction

  function automatic int ent_vpn_lsb(input int pfn_w);
    return pfn_w;
  endfunction

  function automatic int ent_present_bit(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w;
  endfunction

  function automatic int ent_valid_bit(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + 1;
  endfunction

  function automatic int entry_width(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + 2;
  endfunction

endpackage

// File: rtl/tlb_lookup_cache_if.sv
// Lookup request / registered response channel between fetch and the TLB.
interface tlb_lookup_cache_if
  import tlb_pkg::*;
#(
  parameter int VA_W    = DEF_VA_W,
  parameter int LIMIT_W = DEF_LIMIT_W,
  parameter int PFN_W   = DEF_PFN_W
);

  logic               lk_valid;
  logic               lk_ready;
  logic [VA_W-1:0]    lk_vaddr;
  logic [LIMIT_W-1:0] lk_limit;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_hit;
  logic [PFN_W-1:0]   rsp_pfn;
  logic               rsp_page_fault;
  logic               rsp_prot_exp;

  modport master (
    output lk_valid, lk_vaddr, lk_limit, rsp_ready,
    input  lk_ready, rsp_valid, rsp_hit, rsp_pfn, rsp_page_fault, rsp_prot_exp
  );

  modport slave (
    input  lk_valid, lk_vaddr, lk_limit, rsp_ready,
    output lk_ready, rsp_valid, rsp_hit, rsp_pfn, rsp_page_fault, rsp_prot_exp
  );

endinterface

// File: rtl/tlb_match_array.sv
// Fully-associative VPN comparator array: one-hot hit vector plus the
// lowest-index hit, so duplicate matches still resolve deterministically.
module tlb_match_array #(
  parameter int NUM_ENTRIES = 8,
  parameter int VPN_W       = 20,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_ENTRIES-1:0] entry_valid,
  input  logic [NUM_ENTRIES-1:0] entry_qual,
  input  logic [VPN_W-1:0]       entry_vpn [NUM_ENTRIES],
  input  logic [VPN_W-1:0]       key,
  output logic [NUM_ENTRIES-1:0] hit_vec,
  output logic                   any_hit,
  output logic [IDX_W-1:0]       hit_idx
);

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_vec[i] = entry_valid[i] & entry_qual[i] & (entry_vpn[i] == key);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign any_hit = |hit_vec;

endmodule

// File: rtl/tlb_lookup_cache.sv
// Registered fully-associative TLB with in-block fill, invalidate and
// saturating hit/miss counters; one lookup per cycle, one-cycle response.
module tlb_lookup_cache
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int VA_W        = DEF_VA_W,
  parameter int PAGE_OFF_W  = DEF_PAGE_OFF_W,
  parameter int PFN_W       = DEF_PFN_W,
  parameter int LIMIT_W     = DEF_LIMIT_W,
  parameter int LINE_OFF_W  = DEF_LINE_OFF_W,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int VPN_W      = vpn_width(VA_W, PAGE_OFF_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  tlb_lookup_cache_if.slave    lk,
  output logic                 fill_ready,
  input  logic                 fill_valid,
  input  logic [VPN_W-1:0]     fill_vpn,
  input  logic [PFN_W-1:0]     fill_pfn,
  input  logic                 fill_present,
  input  logic                 inv_valid,
  input  logic [VPN_W-1:0]     inv_vpn,
  input  logic                 inv_all,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int ENTRY_W     = entry_width(VPN_W, PFN_W);
  localparam int VPN_LSB     = ent_vpn_lsb(PFN_W);
  localparam int PRESENT_BIT = ent_present_bit(VPN_W, PFN_W);
  localparam int VALID_BIT   = ent_valid_bit(VPN_W, PFN_W);

  logic [ENTRY_W-1:0]     ent_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       ptr_q;
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [NUM_ENTRIES-1:0] present_vec;
  logic [VPN_W-1:0]       vpn_vec [NUM_ENTRIES];
  logic [PFN_W-1:0]       pfn_vec [NUM_ENTRIES];

  logic                   lk_any, dd_any;
  logic [IDX_W-1:0]       lk_idx, dd_idx;
  logic [NUM_ENTRIES-1:0] inv_hit_vec;
  logic [NUM_ENTRIES-1:0] lk_hit_vec_unused, dd_hit_vec_unused;
  logic                   inv_any_unused;
  logic [IDX_W-1:0]       inv_idx_unused;

  logic                   free_any;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       fill_tgt;
  logic                   fill_adv;
  logic                   fill_fire;
  logic                   lk_accept;
  logic [VA_W-1:0]        line_end;
  logic [VA_W-1:0]        limit_ext;

  logic                   rsp_valid_q, rsp_hit_q, rsp_pf_q, rsp_prot_q;
  logic [PFN_W-1:0]       rsp_pfn_q;
  logic [CNT_W-1:0]       hit_cnt_q, miss_cnt_q;

  always_comb begin
    valid_vec   = '0;
    present_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i]   = ent_q[i][VALID_BIT];
      present_vec[i] = ent_q[i][PRESENT_BIT];
      vpn_vec[i]     = ent_q[i][VPN_LSB +: VPN_W];
      pfn_vec[i]     = ent_q[i][0 +: PFN_W];
    end
  end

  // Lookup needs a present translation; fill dedupe and invalidate match any valid VPN.
  tlb_match_array #(.NUM_ENTRIES(NUM_ENTRIES), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_lk_match (
    .entry_valid (valid_vec),
    .entry_qual  (present_vec),
    .entry_vpn   (vpn_vec),
    .key         (lk.lk_vaddr[VA_W-1:PAGE_OFF_W]),
    .hit_vec     (lk_hit_vec_unused),
    .any_hit     (lk_any),
    .hit_idx     (lk_idx)
  );

  tlb_match_array #(.NUM_ENTRIES(NUM_ENTRIES), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_dd_match (
    .entry_valid (valid_vec),
    .entry_qual  ({NUM_ENTRIES{1'b1}}),
    .entry_vpn   (vpn_vec),
    .key         (fill_vpn),
    .hit_vec     (dd_hit_vec_unused),
    .any_hit     (dd_any),
    .hit_idx     (dd_idx)
  );

  tlb_match_array #(.NUM_ENTRIES(NUM_ENTRIES), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_inv_match (
    .entry_valid (valid_vec),
    .entry_qual  ({NUM_ENTRIES{1'b1}}),
    .entry_vpn   (vpn_vec),
    .key         (inv_vpn),
    .hit_vec     (inv_hit_vec),
    .any_hit     (inv_any_unused),
    .hit_idx     (inv_idx_unused)
  );

  always_comb begin
    free_any = ~&valid_vec;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
    fill_tgt = ptr_q;
    fill_adv = 1'b0;
    if (dd_any) begin
      fill_tgt = dd_idx;
    end else if (free_any) begin
      fill_tgt = free_idx;
    end else begin
      fill_adv = 1'b1;
    end
  end

  // A fill racing an invalidate of the same VPN is dropped so the entry ends invalid.
  assign fill_ready = ~inv_all;
  assign fill_fire  = fill_valid & fill_ready & ~(inv_valid & (inv_vpn == fill_vpn));

  assign lk.lk_ready = ~rsp_valid_q | lk.rsp_ready;
  assign lk_accept   = lk.lk_valid & lk.lk_ready;
  assign line_end    = lk.lk_vaddr | VA_W'((64'd1 << LINE_OFF_W) - 64'd1);
  assign limit_ext   = VA_W'(lk.lk_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
      ptr_q <= '0;
    end else if (inv_all) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i][VALID_BIT] <= 1'b0;
      ptr_q <= '0;
    end else begin
      if (fill_fire) begin
        ent_q[fill_tgt] <= {1'b1, fill_present, fill_vpn, fill_pfn};
        if (fill_adv) ptr_q <= ptr_q + 1'b1;
      end
      if (inv_valid) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (inv_hit_vec[i]) ent_q[i][VALID_BIT] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_pfn_q   <= '0;
      rsp_pf_q    <= 1'b0;
      rsp_prot_q  <= 1'b0;
    end else if (lk_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= lk_any;
      rsp_pfn_q   <= lk_any ? pfn_vec[lk_idx] : '0;
      rsp_pf_q    <= ~lk_any;
      rsp_prot_q  <= (line_end > limit_ext);
    end else if (lk.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (cnt_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lk_accept) begin
      if (lk_any && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (!lk_any && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign lk.rsp_valid      = rsp_valid_q;
  assign lk.rsp_hit        = rsp_hit_q;
  assign lk.rsp_pfn        = rsp_pfn_q;
  assign lk.rsp_page_fault = rsp_pf_q;
  assign lk.rsp_prot_exp   = rsp_prot_q;
  assign hit_cnt           = hit_cnt_q;
  assign miss_cnt          = miss_cnt_q;

endmodule
